alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  high when a request can be accepted.
REQ-007 f  input  6  operation code.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 shamt  input  SHW  immediate shift amount.
REQ-010 out_valid  output  1  one-cycle pulse, result present.
REQ-011 y  output  WIDTH  registered result, held until next out_valid.
REQ-012 zero  output  1  registered, (y == 0), updated with y.
REQ-013 div_by_zero  output  1  registered, set with out_valid of DIV/DIVU when b == 0, else cleared on each out_valid.

Function
REQ-014 Acceptance occurs on a rising edge where in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-015 Single-cycle codes 0x00-0x0F SHALL produce: ADD, SUB, AND, OR, XOR, SLL(b<<shamt), SRL, SRA, SLT(signed), SLTU, NOR, SLLV, SRLV, SRAV (variable shifts use a[SHW-1:0]), LUI ({b[WIDTH/2-1:0], zeros}), PASS (y=a); all arithmetic modulo 2^WIDTH.
REQ-016 Codes 0x14 MFHI and 0x15 MFLO SHALL return HI / LO; 0x16 MTHI and 0x17 MTLO SHALL write a to HI / LO and return y=a.
REQ-017 Single-cycle codes and 0x14-0x17 SHALL register y and pulse out_valid on the accepting edge (latency 1); in_ready stays high, back-to-back issue allowed.
REQ-018 Codes 0x10 MULT, 0x11 MULTU, 0x12 DIV, 0x13 DIVU SHALL enter BUSY for exactly WIDTH edges, then FIX for one edge; out_valid, y=LO, and HI/LO update occur on the FIX edge (out_valid high WIDTH+1 edges after the accepting edge).
REQ-019 FSM states IDLE, BUSY, FIX; IDLE->BUSY on accepted mul/div; BUSY->FIX when iteration counter reaches WIDTH-1; FIX->IDLE unconditionally.
REQ-020 MULT/MULTU SHALL yield the 2*WIDTH-bit product, HI = upper half, LO = lower half; signed variant via magnitude iteration plus sign correction in FIX.
REQ-021 DIV/DIVU SHALL yield LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-022 Divide by zero: LO = all ones, HI = a, div_by_zero = 1.
REQ-023 Signed overflow (a = most negative, b = -1): LO = a, HI = 0, div_by_zero = 0.
REQ-024 Unlisted codes SHALL return y = 0, latency 1, HI/LO unchanged.
REQ-025 Operands and f SHALL be latched at acceptance; input changes during BUSY have no effect.
REQ-026 in_valid while not IDLE SHALL be ignored (not queued).

Reset
REQ-027 On rst_n low: state = IDLE, counter = 0, y = 0, zero = 1, out_valid = 0, div_by_zero = 0, HI = LO = 0; an in-flight mul/div is discarded with no out_valid.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode localparams (0x00-0x17) and the FSM state enum.
REQ-030 Sub-module mdu_iter SHALL hold the iterative shift-add / restoring shift-subtract datapath and counter; alu_mdu holds the single-cycle ops, HI/LO, FSM, and output registers.

Verification (WIDTH=32)
REQ-031 ADD a=5, b=0xFFFFFFFB -> next edge out_valid=1, y=0, zero=1; in_ready stays 1; SLT with the same operands issued the next cycle -> y=0.
REQ-032 MULT a=0xFFFFFFFD, b=7 -> out_valid 33 edges after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB; in_ready=0 throughout.
REQ-033 DIVU a=100, b=7 -> LO=14, HI=2; DIV a=0xFFFFFFF9, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then MFHI -> y=0xFFFFFFFF.
REQ-034 DIV a=9, b=0 -> LO=0xFFFFFFFF, HI=9, div_by_zero=1; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 rst_n low at BUSY cycle 10 of MULTU -> no out_valid, HI=LO=0, in_ready=1 after release; fresh ADD 1+2 -> y=3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by alu_mdu and its bench.
package alu_pkg;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SLL   = 6'h05;
  localparam logic [5:0] OP_SRL   = 6'h06;
  localparam logic [5:0] OP_SRA   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_NOR   = 6'h0A;
  localparam logic [5:0] OP_SLLV  = 6'h0B;
  localparam logic [5:0] OP_SRLV  = 6'h0C;
  localparam logic [5:0] OP_SRAV  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0E;
  localparam logic [5:0] OP_PASS  = 6'h0F;
  localparam logic [5:0] OP_MULT  = 6'h10;
  localparam logic [5:0] OP_MULTU = 6'h11;
  localparam logic [5:0] OP_DIV   = 6'h12;
  localparam logic [5:0] OP_DIVU  = 6'h13;
  localparam logic [5:0] OP_MFHI  = 6'h14;
  localparam logic [5:0] OP_MFLO  = 6'h15;
  localparam logic [5:0] OP_MTHI  = 6'h16;
  localparam logic [5:0] OP_MTLO  = 6'h17;

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply (shift-add) / divide (restoring shift-subtract)
// on operand magnitudes, one bit per step, plus combinational sign fix-up of
// the final result.
//   start        : latch operands and clear counter
//   step         : perform one iteration
//   sgn, div     : signed operation / divide (else multiply)
//   a, b         : operands
//   done         : counter at WIDTH-1 (current step is the last)
//   res_hi/lo    : corrected HI/LO result, valid after WIDTH steps
//   dbz          : divide by zero was latched
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             sgn,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dbz
);

  logic [SHW-1:0]   cnt;
  logic             is_div, neg_q, neg_r, dbz_r;
  logic [WIDTH-1:0] m, acc, q, a_raw;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;
  logic [2*WIDTH-1:0] prod_n;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];

  // Multiply: {acc,q} shifts right, adding m into the top half when q[0] set.
  assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  // Divide: acc < m is invariant, so rem_sh < 2m and the difference fits WIDTH bits.
  assign rem_sh  = {acc, q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, m};
  assign rem_sub = rem_sh[WIDTH-1:0] - m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz_r  <= 1'b0;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      a_raw  <= '0;
    end else if (start) begin
      cnt    <= '0;
      is_div <= div;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dbz_r  <= div && (b == '0);
      m      <= b_neg ? -b : b;
      q      <= a_neg ? -a : a;
      acc    <= '0;
      a_raw  <= a;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc <= ge ? rem_sub : rem_sh[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], ge};
      end else begin
        acc <= mul_sum[WIDTH:1];
        q   <= {mul_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  assign done   = (cnt == SHW'(WIDTH-1));
  assign prod_n = neg_q ? -{acc, q} : {acc, q};

  always_comb begin
    res_hi = prod_n[2*WIDTH-1:WIDTH];
    res_lo = prod_n[WIDTH-1:0];
    if (is_div) begin
      if (dbz_r) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -acc : acc;
        res_lo = neg_q ? -q : q;
      end
    end
  end

  assign dbz = dbz_r && is_div;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU with HI/LO registers and an iterative
// multiply/divide unit.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : request handshake (ready only in IDLE)
//   f, a, b, shamt     : opcode, operands, immediate shift amount
//   out_valid          : one-cycle result pulse
//   y, zero            : registered result and (y == 0)
//   div_by_zero        : DIV/DIVU issued with b == 0
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           state, state_nx;
  logic             accept, is_md, md_done, md_dbz;
  logic [WIDTH-1:0] hi, lo, alu_y, md_hi, md_lo;
  logic [SHW-1:0]   sa;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_md    = (f == OP_MULT) || (f == OP_MULTU) || (f == OP_DIV) || (f == OP_DIVU);
  assign sa       = a[SHW-1:0];

  mdu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_md),
    .step   (state == BUSY),
    .sgn    ((f == OP_MULT) || (f == OP_DIV)),
    .div    ((f == OP_DIV) || (f == OP_DIVU)),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .res_hi (md_hi),
    .res_lo (md_lo),
    .dbz    (md_dbz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_md) state_nx = BUSY;
      BUSY:    if (md_done) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (f)
      OP_ADD:  alu_y = a + b;
      OP_SUB:  alu_y = a - b;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_SLL:  alu_y = b << shamt;
      OP_SRL:  alu_y = b >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(b) >>> shamt);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NOR:  alu_y = ~(a | b);
      OP_SLLV: alu_y = b << sa;
      OP_SRLV: alu_y = b >> sa;
      OP_SRAV: alu_y = $unsigned($signed(b) >>> sa);
      OP_LUI:  alu_y = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_PASS: alu_y = a;
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      OP_MTHI: alu_y = a;
      OP_MTLO: alu_y = a;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      y           <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == FIX) begin
        out_valid   <= 1'b1;
        y           <= md_lo;
        zero        <= (md_lo == '0);
        div_by_zero <= md_dbz;
        hi          <= md_hi;
        lo          <= md_lo;
      end else if (accept && !is_md) begin
        out_valid   <= 1'b1;
        y           <= alu_y;
        zero        <= (alu_y == '0);
        div_by_zero <= 1'b0;
        if (f == OP_MTHI) hi <= a;
        if (f == OP_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk, rst_n, in_valid, in_ready, out_valid, zero, div_by_zero;
  logic [5:0]  f;
  logic [31:0] a, b, y;
  logic [4:0]  shamt;
  int          checks = 0, errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .y(y),
    .zero(zero), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] e;
  } vec_t;

  // Present a request for exactly one rising edge; returns #1 after that edge.
  task automatic issue(input logic [5:0] ff, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh);
    @(negedge clk);
    f = ff; a = aa; b = bb; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue a mul/div and count edges until out_valid (0 = timed out).
  // With disturb set, a competing request with other operands is held during BUSY.
  task automatic run_md(input logic [5:0] ff, input logic [31:0] aa, input logic [31:0] bb,
                        input bit disturb, output int lat, output bit rdy_low);
    issue(ff, aa, bb, 5'd0);
    lat = 0;
    rdy_low = !in_ready && !out_valid;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (disturb && i == 2) begin
        f = OP_ADD; a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
      end
      if (i == 20) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid) lat = i;
      else if (in_ready) rdy_low = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; f = '0; a = '0; b = '0; shamt = '0;
    #22;
    checks += 4;
    if (y !== 32'h0)       begin errors++; $display("FAIL reset_y: got %h want 0", y); end
    if (zero !== 1'b1)     begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", y); end
  endtask

  task automatic test_back_to_back;
    issue(OP_ADD, 32'd5, 32'hFFFF_FFFB, 0);
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    if (y !== 32'h0)        begin errors++; $display("FAIL add_y: got %h want 0", y); end
    if (zero !== 1'b1)      begin errors++; $display("FAIL add_zero: got %b want 1", zero); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    issue(OP_SLT, 32'd5, 32'hFFFF_FFFB, 0);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL slt_valid: got %b want 1", out_valid); end
    if (y !== 32'h0)        begin errors++; $display("FAIL slt_y: got %h want 0", y); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", out_valid); end
  endtask

  task automatic test_single;
    vec_t v[$];
    v.push_back('{OP_SUB,  32'd10,        32'd3,          5'd0,  32'd7});
    v.push_back('{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  5'd0,  32'hF000_F000});
    v.push_back('{OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00,  5'd0,  32'hFFF0_FFF0});
    v.push_back('{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,  5'd0,  32'h0FF0_0FF0});
    v.push_back('{OP_SLL,  32'd0,         32'd1,          5'd31, 32'h8000_0000});
    v.push_back('{OP_SRL,  32'd0,         32'h8000_0000,  5'd4,  32'h0800_0000});
    v.push_back('{OP_SRA,  32'd0,         32'h8000_0000,  5'd4,  32'hF800_0000});
    v.push_back('{OP_SLTU, 32'd5,         32'hFFFF_FFFB,  5'd0,  32'd1});
    v.push_back('{OP_SLT,  32'hFFFF_FFFB, 32'd5,          5'd0,  32'd1});
    v.push_back('{OP_NOR,  32'd0,         32'd0,          5'd0,  32'hFFFF_FFFF});
    v.push_back('{OP_SLLV, 32'h23,        32'd1,          5'd0,  32'd8});
    v.push_back('{OP_SRLV, 32'd4,         32'h100,        5'd0,  32'h10});
    v.push_back('{OP_SRAV, 32'd8,         32'h8000_0000,  5'd0,  32'hFF80_0000});
    v.push_back('{OP_LUI,  32'd0,         32'h1234_ABCD,  5'd0,  32'hABCD_0000});
    v.push_back('{OP_PASS, 32'hDEAD_BEEF, 32'd0,          5'd0,  32'hDEAD_BEEF});
    v.push_back('{6'h3F,   32'd7,         32'd9,          5'd0,  32'd0});
    foreach (v[i]) begin
      issue(v[i].f, v[i].a, v[i].b, v[i].sh);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0h_valid: got %b want 1", v[i].f, out_valid); end
      if (y !== v[i].e) begin errors++; $display("FAIL op%0h_y: got %h want %h", v[i].f, y, v[i].e); end
    end
  endtask

  task automatic test_hilo;
    issue(OP_MTHI, 32'h11, 0, 0);
    checks++;
    if (y !== 32'h11) begin errors++; $display("FAIL mthi_y: got %h want 11", y); end
    issue(OP_MTLO, 32'h22, 0, 0);
    issue(6'h2A, 32'h55, 32'h66, 0);
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'h11) begin errors++; $display("FAIL mfhi_after_unlisted: got %h want 11", y); end
    issue(OP_MFLO, 0, 0, 0);
    checks++;
    if (y !== 32'h22) begin errors++; $display("FAIL mflo: got %h want 22", y); end
  endtask

  task automatic test_mult;
    int lat; bit rdy_low;
    run_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, lat, rdy_low);
    checks += 3;
    if (lat != 33)        begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
    if (!rdy_low)         begin errors++; $display("FAIL mult_in_ready: got high during busy want low"); end
    if (y !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", y); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", y); end
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, rdy_low);
    checks++;
    if (y !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 1", y); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", y); end
  endtask

  task automatic test_div;
    int lat; bit rdy_low;
    run_md(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, rdy_low);
    checks += 3;
    if (lat != 33)          begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
    if (y !== 32'd14)       begin errors++; $display("FAIL divu_lo: got %h want e", y); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dbz: got %b want 0", div_by_zero); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", y); end
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, rdy_low);
    checks++;
    if (y !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", y); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", y); end
    run_md(OP_DIV, 32'd9, 32'd0, 1'b0, lat, rdy_low);
    checks += 2;
    if (y !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL dbz_lo: got %h want ffffffff", y); end
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    issue(OP_MFHI, 0, 0, 0);
    checks += 2;
    if (y !== 32'd9)          begin errors++; $display("FAIL dbz_hi: got %h want 9", y); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, rdy_low);
    checks += 2;
    if (y !== 32'h8000_0000)  begin errors++; $display("FAIL ovf_lo: got %h want 80000000", y); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h want 0", y); end
  endtask

  task automatic test_reset_busy;
    int seen = 0;
    issue(OP_MULTU, 32'h1234_5678, 32'd9, 0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rbusy_valid: got %b want 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rbusy_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rbusy_stray_valid: got %0d pulses want 0", seen); end
    issue(OP_MFHI, 0, 0, 0);
    checks++;
    if (y !== 32'h0) begin errors++; $display("FAIL rbusy_hi: got %h want 0", y); end
    issue(OP_MFLO, 0, 0, 0);
    checks++;
    if (y !== 32'h0) begin errors++; $display("FAIL rbusy_lo: got %h want 0", y); end
    issue(OP_ADD, 32'd1, 32'd2, 0);
    checks += 2;
    if (y !== 32'd3)    begin errors++; $display("FAIL rbusy_add: got %h want 3", y); end
    if (zero !== 1'b0)  begin errors++; $display("FAIL rbusy_zero: got %b want 0", zero); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_hilo();
    test_mult();
    test_div();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
